// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: widths, the CDB packet and the ROB age compare
// used by the CDB arbiter, ROB and reservation stations.
package ooo_pkg;

  localparam int ROB_IDX_W = 4;
  localparam int PREG_W    = 7;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] tag;
    logic [PREG_W-1:0]    preg;
    logic                 has_dest;
    logic [DATA_W-1:0]    data;
  } cdb_pkt_t;

  // Ages are distances from the ROB head, so tags that wrap past 2^W still order correctly.
  function automatic logic younger_than(input logic [ROB_IDX_W-1:0] tag,
                                        input logic [ROB_IDX_W-1:0] ref_tag,
                                        input logic [ROB_IDX_W-1:0] head);
    logic [ROB_IDX_W-1:0] age_t;
    logic [ROB_IDX_W-1:0] age_r;
    age_t = tag - head;
    age_r = ref_tag - head;
    return age_t > age_r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: search starts one past ptr and wraps; first requester wins.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one-entry holding register per FU, round-robin grant onto a
// registered common data bus, with squash of results younger than a flush.
module cdb_arbiter
  import ooo_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][ROB_IDX_W-1:0]   req_tag,
  input  logic [NUM_REQ-1:0][PREG_W-1:0]      req_preg,
  input  logic [NUM_REQ-1:0]                  req_has_dest,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]      req_data,
  input  logic [ROB_IDX_W-1:0]                rob_head,
  input  logic                                flush_valid,
  input  logic [ROB_IDX_W-1:0]                flush_tag,
  output logic                                cdb_valid,
  output logic [ROB_IDX_W-1:0]                cdb_tag,
  output logic [PREG_W-1:0]                   cdb_preg,
  output logic                                cdb_has_dest,
  output logic [DATA_W-1:0]                   cdb_data
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic     [NUM_REQ-1:0] full_q, full_d;
  cdb_pkt_t [NUM_REQ-1:0] hold_q, hold_d;
  logic     [IW-1:0]      ptr_q, ptr_d;
  cdb_pkt_t               cdb_q, cdb_d;
  logic                   cdb_valid_q, cdb_valid_d;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  cdb_pkt_t           gpkt;
  logic               any_grant;
  logic               grant_kill;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req   (full_q),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gidx)
  );

  assign req_ready  = ~full_q | grant;
  assign any_grant  = |grant;
  assign gpkt       = hold_q[gidx];
  assign grant_kill = flush_valid & younger_than(gpkt.tag, flush_tag, rob_head);

  always_comb begin
    cdb_pkt_t in_pkt;
    full_d = full_q;
    hold_d = hold_q;
    in_pkt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      in_pkt = '{tag: req_tag[i], preg: req_preg[i], has_dest: req_has_dest[i],
                 data: req_data[i]};
      if (grant[i])
        full_d[i] = 1'b0;
      if (flush_valid && younger_than(hold_q[i].tag, flush_tag, rob_head))
        full_d[i] = 1'b0;
      // A squashed incoming result is dropped even though ready was shown.
      if (req_valid[i] && req_ready[i] &&
          !(flush_valid && younger_than(req_tag[i], flush_tag, rob_head))) begin
        full_d[i] = 1'b1;
        hold_d[i] = in_pkt;
      end
    end
  end

  always_comb begin
    cdb_d       = cdb_q;
    cdb_valid_d = 1'b0;
    ptr_d       = ptr_q;
    if (any_grant) begin
      cdb_d = gpkt;
      if (!grant_kill) begin
        cdb_valid_d = 1'b1;
        ptr_d       = gidx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q      <= '0;
      hold_q      <= '0;
      ptr_q       <= IW'(NUM_REQ - 1);
      cdb_q       <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      hold_q      <= hold_d;
      ptr_q       <= ptr_d;
      cdb_q       <= cdb_d;
      cdb_valid_q <= cdb_valid_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_q.tag;
  assign cdb_preg     = cdb_q.preg;
  assign cdb_has_dest = cdb_q.has_dest;
  assign cdb_data     = cdb_q.data;

endmodule
